// File: rtl/metronome_accent.sv
// Bar-counting metronome: shows the beat (1..BEATS) on one seven-segment digit
// and sounds a fixed-length beep per beat, higher pitched on beat 1.
module metronome_accent #(
  parameter int CLK_HZ      = 27000000,
  parameter int BEATS       = 8,
  parameter int BEEP_CYCLES = CLK_HZ / 5,
  parameter int ACC_HALF    = CLK_HZ / 1760,
  parameter int NORM_HALF   = CLK_HZ / 880
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] bpm,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       speaker_out,
  output logic       beat_pulse
);

  // state | meaning
  // IDLE  | stopped, display "0", silent
  // RUN   | counting beats, accumulating tempo phase, beeping
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] THRESH = 32'(CLK_HZ) * 32'd60;
  localparam int BW   = $clog2(BEEP_CYCLES + 1);
  localparam int MAXH = (ACC_HALF > NORM_HALF) ? ACC_HALF : NORM_HALF;
  localparam int HW   = $clog2(MAXH + 1);
  localparam logic [BW-1:0] BEEP_LD = BW'(BEEP_CYCLES);
  localparam logic [HW-1:0] ACC_H   = HW'(ACC_HALF);
  localparam logic [HW-1:0] NORM_H  = HW'(NORM_HALF);
  localparam logic [3:0]    LAST    = 4'(BEATS);

  if (BEATS < 1 || BEATS > 9) begin : g_bad_beats
    $error("metronome_accent: BEATS must be in 1..9");
  end

  state_t          state;
  logic [31:0]     acc;
  logic [3:0]      beat;
  logic [6:0]      seg;
  logic [BW-1:0]   beep_cnt;
  logic [HW-1:0]   tone_cnt;
  logic [HW-1:0]   half;

  logic [31:0]     sum;
  logic            tick;
  logic [3:0]      beat_nxt;
  logic [HW-1:0]   half_nxt;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1111011;
      default: seg_of = 7'b1111110;
    endcase
  endfunction

  always_comb begin
    sum      = acc + {24'd0, bpm};
    tick     = (sum >= THRESH);
    beat_nxt = (beat == LAST) ? 4'd1 : beat + 4'd1;
    half_nxt = (beat_nxt == 4'd1) ? ACC_H : NORM_H;
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      state       <= IDLE;
      acc         <= '0;
      beat        <= 4'd0;
      seg         <= 7'b1111110;
      beep_cnt    <= '0;
      tone_cnt    <= '0;
      half        <= ACC_H;
      speaker_out <= 1'b0;
      beat_pulse  <= 1'b0;
    end else if (state == IDLE) begin
      state       <= RUN;
      acc         <= '0;
      beat        <= 4'd1;
      seg         <= seg_of(4'd1);
      beat_pulse  <= 1'b1;
      beep_cnt    <= BEEP_LD;
      tone_cnt    <= '0;
      half        <= ACC_H;
      speaker_out <= 1'b1;
    end else if (tick) begin
      // a tick restarts the beep even if the previous one is still sounding
      acc         <= sum - THRESH;
      beat        <= beat_nxt;
      seg         <= seg_of(beat_nxt);
      beat_pulse  <= 1'b1;
      beep_cnt    <= BEEP_LD;
      tone_cnt    <= '0;
      half        <= half_nxt;
      speaker_out <= 1'b1;
    end else begin
      acc        <= sum;
      beat_pulse <= 1'b0;
      if (beep_cnt != '0) begin
        if (beep_cnt == BW'(1)) begin
          beep_cnt    <= '0;
          speaker_out <= 1'b0;
        end else begin
          beep_cnt <= beep_cnt - BW'(1);
          if (tone_cnt == half - HW'(1)) begin
            tone_cnt    <= '0;
            speaker_out <= ~speaker_out;
          end else begin
            tone_cnt <= tone_cnt + HW'(1);
          end
        end
      end
    end
  end

  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: tb/tb_metronome_accent.sv
// Directed bench for metronome_accent: a BEATS=4 instance for scenarios 1-5
// and a BEATS=1 instance for the single-beat bar.
module tb_metronome_accent;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, run2 = 1'b0;
  logic [7:0] bpm = 8'd0, bpm2 = 8'd0;
  logic a1, b1, c1, d1, e1, f1, g1, spk1, pls1;
  logic a2, b2, c2, d2, e2, f2, g2, spk2, pls2;

  int total = 0;
  int bad = 0;
  logic [6:0] seg_tab [0:9];

  always #5 clk = ~clk;

  metronome_accent #(.CLK_HZ(100), .BEATS(4), .BEEP_CYCLES(20), .ACC_HALF(2), .NORM_HALF(4)) u_dut4 (
    .clk(clk), .rst(rst), .run(run), .bpm(bpm),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .speaker_out(spk1), .beat_pulse(pls1));

  metronome_accent #(.CLK_HZ(100), .BEATS(1), .BEEP_CYCLES(20), .ACC_HALF(2), .NORM_HALF(4)) u_dut1 (
    .clk(clk), .rst(rst), .run(run2), .bpm(bpm2),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2),
    .speaker_out(spk2), .beat_pulse(pls2));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // walks one beat from its pulse cycle, checking pulse, digit and tone shape
  task automatic run_beat(input int bt, input int half, input int spacing, input int sel);
    for (int i = 0; i < spacing; i++) begin
      logic p, s;
      logic [6:0] sg;
      p  = (sel == 0) ? pls1 : pls2;
      s  = (sel == 0) ? spk1 : spk2;
      sg = (sel == 0) ? {a1, b1, c1, d1, e1, f1, g1} : {a2, b2, c2, d2, e2, f2, g2};
      chk("pulse", int'(p), (i == 0) ? 1 : 0);
      if (i == 0) chk("seg", int'(sg), int'(seg_tab[bt]));
      chk("spk", int'(s), (i < 20) ? ((((i / half) % 2) == 0) ? 1 : 0) : 0);
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seg"}, int'({a1, b1, c1, d1, e1, f1, g1}), int'(7'b1111110));
    chk({tag, "_spk"}, int'(spk1), 0);
    chk({tag, "_pulse"}, int'(pls1), 0);
  endtask

  initial begin
    int macc, expn, n, bt;
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1111011;

    // 1: reset, then held idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_idle("idle");
      @(negedge clk);
    end

    // 2-3: start at 120 bpm, six beats 50 cycles apart
    run = 1'b1; bpm = 8'd120;
    @(negedge clk);
    run_beat(1, 2, 50, 0);
    run_beat(2, 4, 50, 0);
    run_beat(3, 4, 50, 0);
    run_beat(4, 4, 50, 0);
    run_beat(1, 2, 50, 0);
    run_beat(2, 4, 50, 0);

    // 4: now at beat-3 pulse with the accumulator at 0; switch to 255 bpm
    chk("b3_seg", int'({a1, b1, c1, d1, e1, f1, g1}), int'(seg_tab[3]));
    bpm = 8'd255;
    macc = 0; bt = 3;
    for (int k = 0; k < 12; k++) begin
      expn = 0;
      do begin macc += 255; expn++; end while (macc < 6000);
      macc -= 6000;
      n = 0;
      do begin @(negedge clk); n++; end while (!pls1 && n < 40);
      bt = (bt == 4) ? 1 : bt + 1;
      chk("spacing", n, expn);
      chk("fast_seg", int'({a1, b1, c1, d1, e1, f1, g1}), int'(seg_tab[bt]));
      chk("fast_spk", int'(spk1), 1);
    end

    // 5: stop mid-beep, restart, reset mid-beep
    repeat (5) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk_idle("stop");
    repeat (60) begin
      @(negedge clk);
      chk("stop_pulse", int'(pls1), 0);
    end
    bpm = 8'd120; run = 1'b1;
    @(negedge clk);
    run_beat(1, 2, 50, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst");
    @(negedge clk);
    run_beat(1, 2, 50, 0);

    // 6: single-beat bar at 60 bpm
    run = 1'b0;
    run2 = 1'b1; bpm2 = 8'd60;
    @(negedge clk);
    run_beat(1, 2, 100, 1);
    run_beat(1, 2, 100, 1);
    run_beat(1, 2, 100, 1);
    chk("one_pulse", int'(pls2), 1);
    chk("one_seg", int'({a2, b2, c2, d2, e2, f2, g2}), int'(seg_tab[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/metronome_accent.md
# metronome_accent

Parametrised metronome for the seven-segment and speaker outputs of the FPGA board. It counts beats 1..BEATS in a repeating bar and shows the current beat on one common-cathode seven-segment digit. It sounds a fixed-length square-wave beep at each beat: a higher pitch on beat 1 and a lower pitch on every other beat. Tempo is a runtime BPM input, and a run input starts and stops the metronome.

## Interface
- CLK_HZ, 27000000, clock frequency in Hz. CLK_HZ*60 + 255 must be less than 2^32.
- BEATS, 8, beats per bar, legal range 1..9.
- BEEP_CYCLES, CLK_HZ/5, beep length in clocks, minimum 1.
- ACC_HALF, CLK_HZ/1760, accent tone half-period in clocks (880 Hz), minimum 1.
- NORM_HALF, CLK_HZ/880, normal tone half-period in clocks (440 Hz), minimum 1.
- clk  in  1  system clock. One clock domain only.
- rst  in  1  reset, synchronous and active-high.
- run  in  1  level input: 1 runs the metronome, 0 stops it.
- bpm  in  8  tempo in beats per minute, range 0..255. It is sampled every cycle, so a change takes effect on the next accumulation.
- a, b, c, d, e, f, g  out  1 each  registered segment drives, active-high.
- speaker_out  out  1  registered square-wave tone.
- beat_pulse  out  1  registered. High for one cycle at the start of each beat.

## Operation
- The block has two states, IDLE and RUN. Any cycle with rst=1 forces IDLE on the next edge.
- Reset and IDLE values:
  - beat = 0.
  - Segments show "0": abcdefg = 1111110.
  - speaker_out = 0, beat_pulse = 0.
  - Phase accumulator = 0, beep counter = 0, tone counter = 0.
- IDLE to RUN: when run=1 in IDLE, on the next edge:
  - beat = 1 and beat_pulse = 1.
  - An accent beep starts.
  - The accumulator clears to 0.
- RUN to IDLE: when run=0 in RUN, the next edge returns all IDLE values. Any beep in progress stops and speaker_out goes to 0.
- Tempo accumulator in RUN, with THRESH = CLK_HZ*60:
  - Each cycle, sum = acc + bpm, using 32-bit arithmetic.
  - If sum >= THRESH: acc <= sum - THRESH and a tick occurs.
  - Otherwise: acc <= sum and no tick occurs.
  - The long-run average tick rate is exactly bpm/60 ticks per second.
  - With bpm=0 there are no ticks: the current beat holds and any beep finishes normally.
- On a tick:
  - beat <= (beat == BEATS) ? 1 : beat + 1.
  - beat_pulse = 1 for that cycle.
  - A new beep starts, which restarts any beep still in progress.
  - With BEATS=1, beat stays at 1 and every beep is an accent.
- Beep:
  - The beep counter loads BEEP_CYCLES at the start of the beep.
  - While the counter is nonzero, speaker_out is a square wave and the counter decrements each cycle.
  - When the counter reaches 0, speaker_out = 0.
  - The half-period is ACC_HALF if the beat at beep start is 1, otherwise NORM_HALF. The half-period is latched at beep start.
- Tone:
  - At beep start, speaker_out = 1 and the tone counter = 0.
  - speaker_out toggles after every half-period of cycles while the beep is active.
- Segments decode the beat value:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
- BEATS outside 1..9 is a configuration error and must be flagged at elaboration.

## Timing
- All outputs are registered. Segments, beat_pulse and the first speaker_out=1 change on the same edge that applies the tick or the RUN entry.
- Latency:
  - Tick decision in cycle N: outputs update at the edge ending cycle N.
  - run rising sampled in cycle N: beat 1 is shown after that edge.
- Beep duration: speaker_out is active for exactly BEEP_CYCLES cycles, starting at the beep-start edge.
- Priority when events coincide: rst, then run=0, then tick, then beep countdown.
  - A tick coinciding with the last beep cycle starts the new beep; there is no gap cycle.
- bpm change mid-beat: the accumulator keeps its value, so the beat period adjusts smoothly with no restart.
- Reset mid-beep: speaker_out = 0 on the next edge.

## Test plan
Scenarios 1–5 use CLK_HZ=100, BEATS=4, BEEP_CYCLES=20, ACC_HALF=2, NORM_HALF=4.
1. rst=1 for 3 cycles, then run=0 -> segments 1111110, speaker_out=0, beat_pulse=0 held indefinitely.
2. run goes 1 with bpm=120 -> beat 1 next edge with beat_pulse=1; speaker_out pattern 1,1,0,0 repeating for 20 cycles, then 0; next beat_pulse exactly 50 cycles later, showing 2 (1101101) with half-period 4.
3. Continue 4 more ticks -> beats show 3, 4, 1, 2; the beep after 4 is accent pitch; ticks are spaced 50 cycles apart.
4. bpm=255 -> tick spacing alternates 23/24 cycles with average 6000/255; beeps restart on each tick with no gap.
5. Mid-beep scenarios:
   - run=0 mid-beep -> next edge: segments 1111110, speaker_out=0.
   - run back to 1 -> beat 1 with an accent beep.
   - rst asserted mid-beep -> same result as run=0.
6. BEATS=1, bpm=60, CLK_HZ=100 -> beat_pulse every 100 cycles; display stays 0110000; every beep uses ACC_HALF.
